// File: rtl/ysyx_24080006_mdu_pkg.sv
// Shared execute-stage types for the multiply/divide unit: decoder control
// bundle, op encoding, FSM states and divide fast-path constants.
package ysyx_24080006_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULL = 2'd0,
        MDU_MULH = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_REM  = 2'd3
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        mdu_op_e mdu_op;
        logic    signed_a;
        logic    signed_b;
    } mdu_set_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam logic [31:0] MDU_DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] MDU_OVF_Q  = 32'h8000_0000;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_iter.sv
// One step of unsigned shift-add multiply or restoring divide, sharing a
// single 33-bit adder/subtractor. {hi, lo} is the 64-bit working pair.
module ysyx_24080006_mdu_iter (
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] b,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    logic [32:0] shifted;
    logic [32:0] add_a;
    logic [32:0] add_b;
    logic [32:0] sum;
    logic [32:0] keep;
    logic        ok;

    assign shifted = {hi, lo[31]};
    assign add_a   = is_div ? shifted : {1'b0, hi};
    assign add_b   = is_div ? ~{1'b0, b} : {1'b0, b};
    assign sum     = add_a + add_b + {32'b0, is_div};

    // Partial remainder stays below the divisor, so a set shifted[32] always
    // yields a difference below 2^32 and sum[32] alone flags a borrow.
    assign ok = ~sum[32];

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        keep   = '0;
        if (is_div) begin
            hi_nxt = ok ? sum[31:0] : shifted[31:0];
            lo_nxt = {lo[30:0], ok};
        end else begin
            keep   = lo[0] ? sum : {1'b0, hi};
            hi_nxt = keep[32:1];
            lo_nxt = {keep[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/ysyx_24080006_mdu.sv
// RV32M iterative multiply/divide unit: 32-step shift-add / restoring divide
// on operand magnitudes, sign fix-up on the last step, valid/ready result.
module ysyx_24080006_mdu
    import ysyx_24080006_mdu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  mdu_set_t    mdu_set,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    mdu_state_e  state, state_nxt;
    logic [4:0]  cnt;
    mdu_op_e     op_q;
    logic        neg_q;
    logic [31:0] hi_q, lo_q, b_q;
    logic [31:0] hi_nxt, lo_nxt;

    logic        accept;
    logic        neg_a, neg_b, res_neg;
    logic [31:0] mag_a, mag_b;
    logic        in_div, div0, ovf, fast;
    logic [31:0] fast_res;
    logic [63:0] prod, prod_s;
    logic [31:0] fix_res;

    assign in_ready  = (state == MDU_IDLE);
    assign out_valid = (state == MDU_DONE);
    assign accept    = in_valid && mdu_set.mdu_enable && in_ready && !flush;

    assign neg_a   = mdu_set.signed_a && rs1_data[31];
    assign neg_b   = mdu_set.signed_b && rs2_data[31];
    assign mag_a   = neg_a ? -rs1_data : rs1_data;
    assign mag_b   = neg_b ? -rs2_data : rs2_data;
    assign res_neg = (mdu_set.mdu_op == MDU_REM) ? neg_a : (neg_a ^ neg_b);

    // Divide-by-zero and INT_MIN/-1 bypass the iteration entirely.
    assign in_div = op_is_div(mdu_set.mdu_op);
    assign div0   = (rs2_data == 32'd0);
    assign ovf    = mdu_set.signed_a && mdu_set.signed_b &&
                    (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    assign fast   = in_div && (div0 || ovf);

    always_comb begin
        fast_res = '0;
        if (div0)
            fast_res = (mdu_set.mdu_op == MDU_DIV) ? MDU_DIV0_Q : rs1_data;
        else if (mdu_set.mdu_op == MDU_DIV)
            fast_res = MDU_OVF_Q;
    end

    ysyx_24080006_mdu_iter u_iter (
        .is_div (op_is_div(op_q)),
        .hi     (hi_q),
        .lo     (lo_q),
        .b      (b_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Final sign fix-up applied to the last step's outputs.
    assign prod   = {hi_nxt, lo_nxt};
    assign prod_s = neg_q ? -prod : prod;

    always_comb begin
        fix_res = '0;
        case (op_q)
            MDU_MULL: fix_res = prod_s[31:0];
            MDU_MULH: fix_res = prod_s[63:32];
            MDU_DIV:  fix_res = neg_q ? -lo_nxt : lo_nxt;
            MDU_REM:  fix_res = neg_q ? -hi_nxt : hi_nxt;
            default:  fix_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE: if (accept) state_nxt = fast ? MDU_DONE : MDU_CALC;
            MDU_CALC: if (cnt == 5'd31) state_nxt = MDU_DONE;
            MDU_DONE: if (out_ready) state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
        if (flush) state_nxt = MDU_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            op_q   <= MDU_MULL;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            result <= '0;
        end else if (accept) begin
            cnt   <= '0;
            op_q  <= mdu_set.mdu_op;
            neg_q <= res_neg;
            hi_q  <= '0;
            lo_q  <= mag_a;
            b_q   <= mag_b;
            if (fast) result <= fast_res;
        end else if (state == MDU_CALC && !flush) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) result <= fix_res;
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// Bench for the multiply/divide unit: directed vector table, corner
// sequences, and random ops against a plain-arithmetic reference model.
module tb_ysyx_24080006_mdu;
    import ysyx_24080006_mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    mdu_set_t    mdu_set = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    ysyx_24080006_mdu dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdu_set   (mdu_set),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        mdu_op_e     op;
        logic        sa;
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input mdu_op_e op, input logic sa, input logic sb,
                                          input logic [31:0] a, input logic [31:0] b);
        longint av, bv, r;
        av = sa ? longint'({{32{a[31]}}, a}) : longint'({32'b0, a});
        bv = sb ? longint'({{32{b[31]}}, b}) : longint'({32'b0, b});
        case (op)
            MDU_MULL: begin r = av * bv; return r[31:0]; end
            MDU_MULH: begin r = av * bv; return r[63:32]; end
            MDU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = av / bv; return r[31:0];
            end
            default: begin
                if (b == 0) return a;
                if (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = av % bv; return r[31:0];
            end
        endcase
    endfunction

    // Issue one op with out_ready=1; returns result, cycles from accept edge to out_valid.
    task automatic do_op(input mdu_op_e op, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clock);
        check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
        mdu_set.mdu_enable = 1'b1;
        mdu_set.mdu_op = op;
        mdu_set.signed_a = sa;
        mdu_set.signed_b = sb;
        rs1_data = a;
        rs2_data = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
        res = result;
        @(posedge clock); #1;
    endtask

    vec_t vecs[$];
    logic [31:0] res, held;
    int lat, seen;

    initial begin
        vecs.push_back('{MDU_MULL, 1'b1, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{MDU_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{MDU_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{MDU_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 33});
        vecs.push_back('{MDU_DIV,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33});
        vecs.push_back('{MDU_REM,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33});
        vecs.push_back('{MDU_DIV,  1'b0, 1'b0, 32'd100,       32'd7,          32'd14,        33});
        vecs.push_back('{MDU_REM,  1'b0, 1'b0, 32'd100,       32'd7,          32'd2,         33});
        vecs.push_back('{MDU_DIV,  1'b1, 1'b1, 32'd5,         32'd0,          32'hFFFF_FFFF, 1});
        vecs.push_back('{MDU_REM,  1'b1, 1'b1, 32'd5,         32'd0,          32'd5,         1});
        vecs.push_back('{MDU_DIV,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{MDU_REM,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});

        repeat (3) @(posedge clock);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Request without mdu_enable is ignored.
        @(negedge clock);
        mdu_set = '{mdu_enable: 1'b0, mdu_op: MDU_MULL, signed_a: 1'b0, signed_b: 1'b0};
        in_valid = 1'b1;
        @(posedge clock); #1;
        check("no_enable_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;

        // Backpressure with a held request.
        @(negedge clock);
        mdu_set = '{mdu_enable: 1'b1, mdu_op: MDU_DIV, signed_a: 1'b0, signed_b: 1'b0};
        rs1_data = 32'd100; rs2_data = 32'd7;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        seen = 0;
        while (!out_valid && seen < 100) begin @(posedge clock); #1; seen++; end
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        held = result;
        check("bp_result", held, 32'd14);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("bp_result_stable", result, held);
            check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_after_hs_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_after_hs_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clock); #1;
        check("bp_held_accepted", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin @(posedge clock); #1; seen++; end
        check("bp_second_result", result, 32'd14);
        @(posedge clock); #1;

        // Flush in CALC cycle 10.
        @(negedge clock);
        mdu_set = '{mdu_enable: 1'b1, mdu_op: MDU_MULL, signed_a: 1'b0, signed_b: 1'b0};
        rs1_data = 32'd9; rs2_data = 32'd9;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("flush_no_out_valid", seen, 32'd0);
        do_op(MDU_MULL, 1'b0, 1'b0, 32'd3, 32'd4, res, lat);
        check("after_flush_mull", res, 32'd12);

        // Asynchronous reset in CALC cycle 20.
        @(negedge clock);
        mdu_set = '{mdu_enable: 1'b1, mdu_op: MDU_MULH, signed_a: 1'b1, signed_b: 1'b1};
        rs1_data = 32'h1234_5678; rs2_data = 32'h9abc_def0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        do_op(MDU_MULL, 1'b0, 1'b0, 32'd3, 32'd4, res, lat);
        check("after_reset_mull", res, 32'd12);

        // Random ops against the arithmetic model.
        for (int n = 0; n < 60; n++) begin
            mdu_op_e     op;
            logic        sa, sb;
            logic [31:0] a, b;
            op = mdu_op_e'($urandom_range(3, 0));
            sa = 1'($urandom_range(1, 0));
            sb = 1'($urandom_range(1, 0));
            case ($urandom_range(5, 0))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(6, 0))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(15, 1);
                default: b = $urandom;
            endcase
            do_op(op, sa, sb, a, b, res, lat);
            check($sformatf("rand%0d_op%0d_%h_%h", n, op, a, b), res, model(op, sa, sb, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_mdu.md
# ysyx_24080006_mdu

Iterative multiply/divide unit for the RV32M extension, sitting in the execute stage beside the ALU. It consumes the `mdu_set_t` control bundle produced by the decoder together with the rs1/rs2 operands, runs a 32-step shift-add multiply or shift-subtract divide, and returns a 32-bit result to writeback through a valid/ready handshake. The pipeline stalls on `in_ready`/`out_valid` while the unit is busy.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill. Aborts any operation and discards any held result.
- `in_valid`  in  1  request valid. Qualified by `mdu_set.mdu_enable`.
- `in_ready`  out  1  unit is idle and can accept a request.
- `mdu_set`  in  `$bits(mdu_set_t)`  fields: `mdu_op` (MULL/MULH/DIV/REM), `signed_a`, `signed_b`.
- `rs1_data`  in  32  operand A (multiplicand or dividend).
- `rs2_data`  in  32  operand B (multiplier or divisor).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  32  result value.

## Operation
- The FSM has three states: `MDU_IDLE`, `MDU_CALC`, `MDU_DONE`.
- Accept condition: `in_valid && mdu_set.mdu_enable && in_ready && !flush`. `in_ready` equals `state == MDU_IDLE`.
- On accept, the unit latches `mdu_op` and computes operand magnitudes.
  - Operand A is negated when `signed_a && rs1_data[31]`.
  - Operand B is negated when `signed_b && rs2_data[31]`.
  - For the multiply ops, the result sign is `negA ^ negB`.
  - For DIV, the quotient sign is `negA ^ negB`.
  - For REM, the remainder sign is `negA`.
- The multiply ops use an unsigned 32x32 shift-add. MULL returns `prod[31:0]`. MULH returns `prod[63:32]` after the 64-bit two's-complement fix-up. MULH/MULHSU/MULHU are distinguished only by `signed_a`/`signed_b`.
- The divide ops use unsigned restoring division. Each step shifts the 33-bit partial remainder left by one, subtracts the divisor, and keeps the result if it is non-negative. The quotient bit is shifted in.
- Fast path, taken when the accept cycle is followed directly by `MDU_DONE` with no CALC:
  - Divisor is zero: DIV returns `0xFFFFFFFF`, REM returns `rs1_data`. This holds regardless of signedness.
  - Signed overflow (`signed_a && signed_b`, `rs1_data == 0x80000000`, `rs2_data == 0xFFFFFFFF`): DIV returns `0x80000000`, REM returns `0`.
- The 5-bit iteration counter counts 0..31 in `MDU_CALC`. At count 31, the final sign fix-up is written into the result register and the state moves to `MDU_DONE`.
- In `MDU_DONE`, `out_valid` is 1 and `result` is stable until `out_ready`. On `out_valid && out_ready` the state moves to `MDU_IDLE`.
- `flush` in any state moves the FSM to `MDU_IDLE` on the next edge, with `out_valid` deasserted. Flush wins over a same-cycle accept or handshake.

## Timing
- Reset values: state `MDU_IDLE`, `in_ready` 1, `out_valid` 0, `result` 0, counter 0, all datapath registers 0.
- Normal latency: with accept at edge N, `out_valid` rises after edge N+33 (one cycle of IDLE→CALC, then 32 CALC cycles).
- Fast-path latency: `out_valid` rises after edge N+1.
- Earliest back-to-back: with `out_ready` tied to 1, the next accept can occur the cycle after the output handshake. Throughput is therefore one op per 34 cycles (one per 2 on the fast path).
- `result` is registered, with no combinational path from inputs to `result` or `out_valid`.
- `in_ready` depends only on state. It must not depend on `in_valid`.
- Asserting `reset_n` low mid-operation clears everything immediately and asynchronously. Release of reset is synchronous to `clock`.

## Structure
- `mdu_set_t` and `mdu_op_e` already exist in the shared package.
- Add `mdu_state_e` (`MDU_IDLE`, `MDU_CALC`, `MDU_DONE`) to the shared package.
- Add to the shared package the constants `MDU_DIV0_Q = 32'hFFFF_FFFF` and `MDU_OVF_Q = 32'h8000_0000`.
- One sub-module, `ysyx_24080006_mdu_iter`: the combinational single-step datapath. It holds a 33-bit adder/subtractor plus shift logic selected by a mul/div flag.
- The top level holds the FSM, counter, operand/accumulator registers, and sign fix-up.

## Test plan
- MULL, signed, 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB, with `out_valid` exactly 33 cycles after accept.
- MULH with `signed_a`=`signed_b`=1, 0x80000000 × 0x80000000 → 0x40000000. MULH unsigned (MULHU), 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU, 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV signed, 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM signed, same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU → 2.
- Fast path: DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `out_valid` one cycle after accept. Signed 0x80000000 / 0xFFFFFFFF → DIV 0x80000000, REM 0.
- Backpressure: hold `out_ready`=0 for 5 cycles in `MDU_DONE`. `result` stays stable, `in_ready` stays 0, and a held `in_valid` is not accepted until one cycle after the handshake.
- Kill and reset:
  - `flush` at CALC cycle 10 → `in_ready`=1 next cycle, and no `out_valid` follows.
  - `reset_n` low at CALC cycle 20 → all outputs return immediately to their reset values.
  - A fresh MULL 3×4 after either event → 12.
